// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types, opcodes and decode helper for the K&S datapath.
// Optional feature macro: KS_DP_SHIFT_EN (enables SHL/SHR opcodes).
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BOV,
        I_BNOV,
        I_BNNEG,
        I_HALT,
        I_CALL,
        I_RET,
        I_SHL,
        I_SHR
    } decoded_instruction_type;

    // 110 and 111 are deliberately unnamed; the ALU treats them as OR.
    typedef enum logic [2:0] {
        ALU_OR  = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_AND = 3'b011,
        ALU_SHL = 3'b100,
        ALU_SHR = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_TARGET = 2'b01,
        PC_LINK   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_src_t;

    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_SHL    = 8'hA5;
    localparam logic [7:0] OP_SHR    = 8'hA6;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BOV    = 8'h05;
    localparam logic [7:0] OP_BNOV   = 8'h06;
    localparam logic [7:0] OP_CALL   = 8'h07;
    localparam logic [7:0] OP_RET    = 8'h08;
    localparam logic [7:0] OP_BNNEG  = 8'h0A;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    // Map an 8-bit opcode to its instruction class; unknown opcodes are NOP.
    function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
        decoded_instruction_type d;
        case (opc)
            OP_LOAD:   d = I_LOAD;
            OP_STORE:  d = I_STORE;
            OP_MOVE:   d = I_MOVE;
            OP_ADD:    d = I_ADD;
            OP_SUB:    d = I_SUB;
            OP_AND:    d = I_AND;
            OP_OR:     d = I_OR;
`ifdef KS_DP_SHIFT_EN
            OP_SHL:    d = I_SHL;
            OP_SHR:    d = I_SHR;
`endif
            OP_BRANCH: d = I_BRANCH;
            OP_BZERO:  d = I_BZERO;
            OP_BNEG:   d = I_BNEG;
            OP_BOV:    d = I_BOV;
            OP_BNOV:   d = I_BNOV;
            OP_CALL:   d = I_CALL;
            OP_RET:    d = I_RET;
            OP_BNNEG:  d = I_BNNEG;
            OP_HALT:   d = I_HALT;
            default:   d = I_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ks_data_path_gen_alu.sv
// ks_alu: combinational K&S ALU producing a result and four status flags.
// Optional feature macro: KS_DP_SHIFT_EN (SHL/SHR by one bit on operand A).
module ks_alu
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg,
    output logic              unsigned_overflow,
    output logic              signed_overflow
);

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] b_eff;
    logic              carry_in_msb;

    // Compute result and flags; overflow flags stay 0 unless the op defines them.
    always_comb begin
        sum_ext           = '0;
        b_eff             = '0;
        carry_in_msb      = 1'b0;
        result            = a | b;
        unsigned_overflow = 1'b0;
        signed_overflow   = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                // SUB is A + ~B + 1, so carry-out 1 means no borrow.
                b_eff   = (op == ALU_SUB) ? ~b : b;
                sum_ext = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, (op == ALU_SUB)};
                result  = sum_ext[DATA_W-1:0];
                carry_in_msb      = sum_ext[DATA_W-1] ^ a[DATA_W-1] ^ b_eff[DATA_W-1];
                unsigned_overflow = sum_ext[DATA_W];
                signed_overflow   = carry_in_msb ^ sum_ext[DATA_W];
            end
            ALU_AND: result = a & b;
`ifdef KS_DP_SHIFT_EN
            ALU_SHL: begin
                result            = {a[DATA_W-2:0], 1'b0};
                unsigned_overflow = a[DATA_W-1];
            end
            ALU_SHR: begin
                result            = {1'b0, a[DATA_W-1:1]};
                unsigned_overflow = a[0];
            end
`endif
            default: result = a | b;
        endcase
        zero = (result == '0);
        neg  = result[DATA_W-1];
    end

endmodule

// File: rtl/ks_data_path_gen.sv
// ks_data_path_gen: K&S generation-2 datapath (PC, IR, link register,
// register file, ALU and flag register), driven by control-unit enables.
// Optional feature macro: KS_DP_SHIFT_EN (SHL/SHR opcodes and ALU ops).
module ks_data_path_gen
    import k_and_s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ir_enable,
    input  logic                    pc_enable,
    input  pc_src_t                 pc_src,
    input  logic                    link_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  alu_op_t                 operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    input  logic [DATA_W-1:0]       data_in,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out
);

    localparam int RA_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_reg;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [ADDR_W-1:0] target;
    logic [RA_W-1:0]   a_addr;
    logic [RA_W-1:0]   b_addr;
    logic [RA_W-1:0]   c_addr;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] bus_c;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_neg;
    logic              alu_uov;
    logic              alu_sov;
    logic              ir_unused;

    // Not every IR bit is a field for every instruction.
    assign ir_unused = ^ir;

    assign decoded_instruction = decode_opcode(ir[DATA_W-1 -: 8]);
    assign target              = ir[ADDR_W-1:0];

    // Select register-file ports from the IR fields of the decoded instruction.
    always_comb begin
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        case (decoded_instruction)
            I_LOAD:  c_addr = ir[ADDR_W+RA_W-1:ADDR_W];
            I_STORE: a_addr = ir[ADDR_W+RA_W-1:ADDR_W];
            I_MOVE: begin
                // Source drives both ALU ports so an OR passes it through.
                a_addr = ir[RA_W-1:0];
                b_addr = ir[RA_W-1:0];
                c_addr = ir[2*RA_W-1:RA_W];
            end
            I_ADD, I_SUB, I_AND, I_OR, I_SHL, I_SHR: begin
                a_addr = ir[RA_W-1:0];
                b_addr = ir[2*RA_W-1:RA_W];
                c_addr = ir[2*RA_W-1:RA_W];
            end
            default: ;
        endcase
    end

    assign bus_a    = regs[a_addr];
    assign bus_b    = regs[b_addr];
    assign bus_c    = c_sel ? alu_result : data_in;
    assign data_out = bus_a;
    assign ram_addr = addr_sel ? target : pc;

    ks_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a                 (bus_a),
        .b                 (bus_b),
        .op                (operation),
        .result            (alu_result),
        .zero              (alu_zero),
        .neg               (alu_neg),
        .unsigned_overflow (alu_uov),
        .signed_overflow   (alu_sov)
    );

    // IR, PC and link register; link captures the pre-update PC, giving CALL and swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= '0;
            pc       <= '0;
            link_reg <= '0;
        end else begin
            if (ir_enable) begin
                ir <= data_in;
            end
            if (pc_enable) begin
                case (pc_src)
                    PC_INC:    pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    PC_TARGET: pc <= target;
                    PC_LINK:   pc <= link_reg;
                    default:   pc <= pc;
                endcase
            end
            if (link_enable) begin
                link_reg <= pc;
            end
        end
    end

    // Register file write port; reads are combinational without bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_reg_enable) begin
            regs[c_addr] <= bus_c;
        end
    end

    // Flag register loaded from the ALU on request.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= alu_zero;
            neg_op            <= alu_neg;
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

endmodule
